link_test_ctrl: RTL

//  Sequences one loopback burst test over the FPGA-to-FPGA link.

---
 rtl/link_test_ctrl_pkg.sv | 20 ++
 rtl/link_test_ctrl_if.sv | 25 ++
 rtl/link_test_ctrl_pattern_gen.sv | 21 ++
 rtl/link_test_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/link_test_ctrl_pkg.sv
// Shared types and constants for the FPGA-to-FPGA link loopback test controller.
package link_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_PASS,
    ST_FAIL
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_EXTRA   = 2'd3;

endpackage

// File: rtl/link_test_ctrl_if.sv
// Sender/receiver link and status bundle between the test controller and the link.
interface link_test_ctrl_if #(parameter int unsigned DATA_W = link_pkg::DATA_W_DEF);

  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_word_ack;
  logic              tx_done;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              led;
  logic [15:0]       err_cnt;
  logic [1:0]        fail_code;

  modport master (
    output tx_start, tx_data, busy, led, err_cnt, fail_code,
    input  tx_word_ack, tx_done, rx_valid, rx_data
  );

  modport slave (
    input  tx_start, tx_data, busy, led, err_cnt, fail_code,
    output tx_word_ack, tx_done, rx_valid, rx_data
  );

endinterface

// File: rtl/link_test_ctrl_pattern_gen.sv
// Decrementing pattern register: loads SEED, steps down by one (mod 2^DATA_W).
module link_pattern_gen
  import link_pkg::*;
#(
  parameter int unsigned       DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SEED   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] word
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      word <= SEED;
    else if (load) word <= SEED;
    else if (step) word <= word - DATA_W'(1);
  end

endmodule

// File: rtl/link_test_ctrl.sv
// Runs one loopback burst: arms the sender, streams the pattern, checks echoed words,
// times out a stalled link and reports the verdict on led/fail_code.
module link_test_ctrl
  import link_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       SEND_COUNT = 100,
  parameter logic [DATA_W-1:0] SEED       = '1,
  parameter int unsigned       TIMEOUT    = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  link_test_ctrl_if.master  lnk
);

  localparam int unsigned    CNT_W    = $clog2(SEND_COUNT + 1);
  localparam int unsigned    TMR_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEND_COUNT);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(SEND_COUNT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT - 1);

  state_t            state;
  logic              en_q, en_q2;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic [TMR_W-1:0]  timer;
  logic              done_seen;
  logic              tx_start, busy, led;
  logic [15:0]       err_cnt;
  logic [1:0]        fail_code;
  logic [DATA_W-1:0] tx_word, rx_exp;

  logic active_c, start_c, tx_ack_c, tx_step_c, rx_extra_c, rx_chk_c, mism_c, timeout_c;

  always_comb begin
    active_c   = (state == ST_RUN) || (state == ST_DRAIN);
    start_c    = en_q && !en_q2 &&
                 ((state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL));
    tx_ack_c   = (state == ST_RUN) && lnk.tx_word_ack && (tx_cnt != CNT_LAST);
    // the final accepted word stays on tx_data rather than stepping past the burst
    tx_step_c  = tx_ack_c && (tx_cnt != CNT_PEN);
    rx_extra_c = active_c && lnk.rx_valid && (rx_cnt == CNT_LAST);
    rx_chk_c   = active_c && lnk.rx_valid && (rx_cnt != CNT_LAST);
    mism_c     = rx_chk_c && (lnk.rx_data != rx_exp);
    timeout_c  = active_c && !lnk.tx_word_ack && !lnk.rx_valid && (timer == TMR_MAX);
  end

  link_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_tx_pat (
    .clk(clk), .rst(rst), .load(start_c), .step(tx_step_c), .word(tx_word)
  );

  link_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED)) u_rx_pat (
    .clk(clk), .rst(rst), .load(start_c), .step(rx_chk_c), .word(rx_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      en_q      <= 1'b0;
      en_q2     <= 1'b0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      timer     <= '0;
      done_seen <= 1'b0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      led       <= 1'b0;
      err_cnt   <= '0;
      fail_code <= FC_NONE;
    end else begin
      en_q     <= en;
      en_q2    <= en_q;
      tx_start <= 1'b0;
      if (lnk.tx_done) done_seen <= 1'b1;

      // datapath bookkeeping while the burst is live
      if (active_c) begin
        tx_cnt <= tx_cnt + CNT_W'(tx_ack_c);
        rx_cnt <= rx_cnt + CNT_W'(rx_chk_c);
        if (lnk.tx_word_ack || lnk.rx_valid) timer <= '0;
        else if (!timeout_c)                 timer <= timer + TMR_W'(1);
        if (mism_c && (err_cnt != 16'hFFFF)) err_cnt   <= err_cnt + 16'd1;
        if (mism_c && (fail_code == FC_NONE)) fail_code <= FC_DATA;
      end

      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start_c) begin
            state     <= ST_ARM;
            tx_start  <= 1'b1;
            busy      <= 1'b1;
            led       <= 1'b0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            timer     <= '0;
            err_cnt   <= '0;
            fail_code <= FC_NONE;
            done_seen <= 1'b0;
          end
        end
        ST_ARM: state <= ST_RUN;
        ST_RUN, ST_DRAIN: begin
          if (rx_extra_c) begin
            state     <= ST_FAIL;
            busy      <= 1'b0;
            fail_code <= FC_EXTRA;
          end else if (timeout_c) begin
            state     <= ST_FAIL;
            busy      <= 1'b0;
            fail_code <= FC_TIMEOUT;
          end else if ((state == ST_RUN) && (tx_cnt == CNT_LAST) &&
                       (done_seen || lnk.tx_done)) begin
            state <= ST_DRAIN;
          end else if ((state == ST_DRAIN) && (rx_cnt == CNT_LAST)) begin
            busy <= 1'b0;
            if (err_cnt == 16'd0) begin
              state <= ST_PASS;
              led   <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              fail_code <= FC_DATA;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          led   <= 1'b0;
        end
      endcase
    end
  end

  assign lnk.tx_start  = tx_start;
  assign lnk.tx_data   = tx_word;
  assign lnk.busy      = busy;
  assign lnk.led       = led;
  assign lnk.err_cnt   = err_cnt;
  assign lnk.fail_code = fail_code;

endmodule
